// File: rtl/gol_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gol_step_sequencer
// Purpose  : Computes one Game-of-Life generation into the back bank, then
//            swaps banks on the display frame boundary.
// Options  : define GOL_TORUS_EN for toroidal (wrap-around) board edges.
// Revision : 1.0 - initial release
// ============================================================================
module gol_step_sequencer #(
  parameter int COLS  = 20,
  parameter int ROWS  = 15,
  parameter int AW    = 9,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_req,
  input  logic             frame_sync,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic             rd_data,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic             wr_data,
  output logic             front_bank,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count
);

  localparam int c_XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DRAIN     = 3'd2,
    S_WRITE     = 3'd3,
    S_WAIT_SWAP = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_XW-1:0] r_x;
  logic [c_YW-1:0] r_y;
  logic [3:0]      r_k;
  logic [3:0]      r_count;
  logic            r_self;
  logic            r_acc_en;
  logic [3:0]      r_acc_k;

  logic            w_last_x;
  logic            w_last_cell;
  logic [c_XW-1:0] w_next_x;
  logic [c_YW-1:0] w_next_y;
  logic [c_XW-1:0] w_ix;
  logic [c_YW-1:0] w_iy;
  logic [3:0]      w_ik;
  int              w_nx;
  int              w_ny;
  logic            w_iss_en;
  logic [AW-1:0]   w_iss_addr;
  logic [3:0]      w_count;
  logic            w_self;
  logic            w_next_cell;

  assign w_last_x    = (r_x == c_XW'(COLS - 1));
  assign w_last_cell = w_last_x && (r_y == c_YW'(ROWS - 1));
  assign w_next_x    = w_last_x ? '0 : r_x + c_XW'(1);
  assign w_next_y    = w_last_x ? r_y + c_YW'(1) : r_y;

  // Cursor and neighbour index of the read issued at the coming edge.
  always_comb begin
    w_ix = r_x;
    w_iy = r_y;
    w_ik = r_k + 4'd1;
    case (r_state)
      S_IDLE: begin
        w_ix = '0;
        w_iy = '0;
        w_ik = 4'd0;
      end
      S_WRITE: begin
        w_ix = w_next_x;
        w_iy = w_next_y;
        w_ik = 4'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nx     = int'(w_ix) + (int'(w_ik) % 3) - 1;
    w_ny     = int'(w_iy) + (int'(w_ik) / 3) - 1;
    w_iss_en = 1'b1;
`ifdef GOL_TORUS_EN
    if (w_nx < 0)
      w_nx = COLS - 1;
    else if (w_nx >= COLS)
      w_nx = 0;
    if (w_ny < 0)
      w_ny = ROWS - 1;
    else if (w_ny >= ROWS)
      w_ny = 0;
`else
    if (w_nx < 0 || w_nx >= COLS || w_ny < 0 || w_ny >= ROWS) begin
      w_iss_en = 1'b0;
      w_nx     = 0;
      w_ny     = 0;
    end
`endif
    w_iss_addr = AW'(w_ny * COLS + w_nx);
  end

  // Fold in the read data returned this cycle (issued one cycle earlier).
  always_comb begin
    w_count = r_count;
    w_self  = r_self;
    if (r_acc_en) begin
      if (r_acc_k == 4'd4)
        w_self = rd_data;
      else if (rd_data)
        w_count = r_count + 4'd1;
    end
    w_next_cell = (w_self && w_count == 4'd2) || (w_count == 4'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_k        <= '0;
      r_count    <= '0;
      r_self     <= 1'b0;
      r_acc_en   <= 1'b0;
      r_acc_k    <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 1'b0;
      front_bank <= 1'b0;
      busy       <= 1'b0;
      gen_count  <= '0;
    end else begin
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      r_acc_en <= rd_en;
      r_acc_k  <= r_k;
      r_count  <= w_count;
      r_self   <= w_self;
      case (r_state)
        S_IDLE: begin
          if (step_req) begin
            busy    <= 1'b1;
            r_x     <= '0;
            r_y     <= '0;
            r_k     <= '0;
            r_count <= '0;
            rd_en   <= w_iss_en;
            rd_addr <= w_iss_addr;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_k == 4'd8) begin
            r_state <= S_DRAIN;
          end else begin
            r_k     <= r_k + 4'd1;
            rd_en   <= w_iss_en;
            rd_addr <= w_iss_addr;
          end
        end
        S_DRAIN: begin
          wr_en   <= 1'b1;
          wr_addr <= AW'(int'(r_y) * COLS + int'(r_x));
          wr_data <= w_next_cell;
          r_count <= '0;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_k <= '0;
          if (w_last_cell) begin
            r_state <= S_WAIT_SWAP;
          end else begin
            r_x     <= w_next_x;
            r_y     <= w_next_y;
            rd_en   <= w_iss_en;
            rd_addr <= w_iss_addr;
            r_state <= S_FETCH;
          end
        end
        S_WAIT_SWAP: begin
          if (frame_sync) begin
            front_bank <= ~front_bank;
            gen_count  <= gen_count + GEN_W'(1);
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gol_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gol_step_sequencer
// Purpose  : Self-checking bench: board RAM model plus Game-of-Life reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gol_step_sequencer;
  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int AW    = 9;
  localparam int GEN_W = 16;
  localparam int N     = COLS * ROWS;
  localparam int SWEEP = 11 * N;
`ifdef GOL_TORUS_EN
  localparam bit TORUS = 1'b1;
`else
  localparam bit TORUS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             step_req = 1'b0;
  logic             frame_sync = 1'b0;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic             rd_data = 1'b0;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             wr_data;
  logic             front_bank;
  logic             busy;
  logic [GEN_W-1:0] gen_count;

  int checks = 0;
  int errors = 0;

  bit mem [2][N];
  bit load_req = 1'b0;
  bit load_board [N];
  bit load_junk [N];
  bit pat [N];

  gol_step_sequencer #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .GEN_W(GEN_W)) dut (
    .clk(clk), .rst(rst), .step_req(step_req), .frame_sync(frame_sync),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .front_bank(front_bank), .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  // Double-buffered board RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) begin
        mem[front_bank][i]  <= load_board[i];
        mem[~front_bank][i] <= load_junk[i];
      end
    end else begin
      if (rd_en) rd_data <= (int'(rd_addr) < N) ? mem[front_bank][rd_addr] : 1'b0;
      if (wr_en && int'(wr_addr) < N) mem[~front_bank][wr_addr] <= wr_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int live_neighbours(input bit b[N], input int x, input int y);
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int nx = x + dx;
        int ny = y + dy;
        if (dx == 0 && dy == 0) continue;
        if (TORUS) begin
          nx = (nx + COLS) % COLS;
          ny = (ny + ROWS) % ROWS;
        end else if (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS) continue;
        c += int'(b[ny * COLS + nx]);
      end
    return c;
  endfunction

  function automatic void next_gen(input bit b[N], output bit nb[N]);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        int c = live_neighbours(b, x, y);
        nb[y * COLS + x] = b[y * COLS + x] ? (c == 2 || c == 3) : (c == 3);
      end
  endfunction

  function automatic int expected_reads();
    int r = 0;
    if (TORUS) return 9 * N;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (x + dx >= 0 && x + dx < COLS && y + dy >= 0 && y + dy < ROWS) r++;
    return r;
  endfunction

  function automatic int front_diff(input bit b[N]);
    int d = 0;
    for (int i = 0; i < N; i++) if (mem[front_bank][i] != b[i]) d++;
    return d;
  endfunction

  task automatic clear_pat;
    for (int i = 0; i < N; i++) pat[i] = 1'b0;
  endtask

  task automatic set_pat(input int x, input int y);
    pat[y * COLS + x] = 1'b1;
  endtask

  task automatic load_front(input bit b[N]);
    for (int i = 0; i < N; i++) begin
      load_board[i] = b[i];
      load_junk[i]  = 1'($urandom_range(0, 1));
    end
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
  endtask

  // Full generation: step, sweep, optional hold-off, frame_sync, swap.
  task automatic do_generation(input int hold, input bit spam);
    bit cur [N];
    bit exp [N];
    int nwr = 0, nrd = 0, last_wr = -1, busy_lo = 0, idle_act = 0, bad_rd = 0, flips = 0;
    logic f0;
    logic [GEN_W-1:0] g0;
    for (int i = 0; i < N; i++) cur[i] = mem[front_bank][i];
    next_gen(cur, exp);
    f0 = front_bank;
    g0 = gen_count;
    step_req = 1'b1;
    tick;
    step_req = 1'b0;
    checks++;
    if (TORUS ? !(rd_en === 1'b1 && rd_addr === AW'(N - 1)) : (rd_en !== 1'b0)) begin
      errors++;
      $display("FAIL first_issue: rd_en=%b rd_addr=%0d torus=%0d", rd_en, rd_addr, TORUS);
    end
    for (int t = 0; t < SWEEP + hold; t++) begin
      if (busy !== 1'b1) busy_lo++;
      if (front_bank !== f0) flips++;
      if (t >= SWEEP && (rd_en !== 1'b0 || wr_en !== 1'b0)) idle_act++;
      if (rd_en === 1'b1) begin
        nrd++;
        if (int'(rd_addr) >= N) bad_rd++;
      end
      if (wr_en === 1'b1) begin
        checks++;
        if (nwr >= N || wr_addr !== AW'(nwr) || wr_data !== exp[nwr]) begin
          errors++;
          $display("FAIL write[%0d]: addr=%0d data=%b expected addr=%0d data=%b",
                   nwr, wr_addr, wr_data, nwr, (nwr < N) ? exp[nwr] : 1'b0);
        end
        nwr++;
        last_wr = t;
      end
      step_req   = spam && (t % 100 == 50);
      frame_sync = spam && ((t % 100 == 70 && t < SWEEP - 1) || t == SWEEP - 1);
      tick;
    end
    step_req = 1'b0;
    checks++;
    if (nwr != N) begin errors++; $display("FAIL write_count: got %0d expected %0d", nwr, N); end
    checks++;
    if (last_wr != SWEEP - 1) begin
      errors++; $display("FAIL sweep_length: last write at %0d expected %0d", last_wr, SWEEP - 1);
    end
    checks++;
    if (nrd != expected_reads()) begin
      errors++; $display("FAIL read_count: got %0d expected %0d", nrd, expected_reads());
    end
    checks++;
    if (bad_rd != 0) begin errors++; $display("FAIL read_range: %0d reads out of board", bad_rd); end
    checks++;
    if (busy_lo != 0) begin errors++; $display("FAIL busy_held: low for %0d cycles expected 0", busy_lo); end
    checks++;
    if (idle_act != 0) begin errors++; $display("FAIL wait_quiet: %0d strobe cycles expected 0", idle_act); end
    checks++;
    if (flips != 0) begin errors++; $display("FAIL front_stable: changed %0d cycles expected 0", flips); end
    frame_sync = 1'b1;
    tick;
    frame_sync = 1'b0;
    checks++;
    if (front_bank !== ~f0 || gen_count !== g0 + GEN_W'(1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL swap: front=%b gen=%0d busy=%b expected front=%b gen=%0d busy=0",
               front_bank, gen_count, busy, ~f0, g0 + GEN_W'(1));
    end
    checks++;
    if (front_diff(exp) != 0) begin
      errors++; $display("FAIL board: %0d cells differ from reference, expected 0", front_diff(exp));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if ({rd_en, wr_en, wr_data, front_bank, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: rd_en=%b wr_en=%b wr_data=%b front=%b busy=%b expected all 0",
                         rd_en, wr_en, wr_data, front_bank, busy);
    end
    checks++;
    if (rd_addr !== '0 || wr_addr !== '0) begin
      errors++; $display("FAIL reset_addr: rd_addr=%0d wr_addr=%0d expected 0", rd_addr, wr_addr);
    end
    checks++;
    if (gen_count !== '0) begin errors++; $display("FAIL reset_gen: got %0d expected 0", gen_count); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_block;
    apply_reset;
    clear_pat;
    set_pat(4, 4); set_pat(5, 4); set_pat(4, 5); set_pat(5, 5);
    load_front(pat);
    do_generation(7, 1'b0);
    checks++;
    if (front_diff(pat) != 0 || front_bank !== 1'b1 || gen_count !== GEN_W'(1)) begin
      errors++; $display("FAIL block: diff=%0d front=%b gen=%0d expected 0/1/1",
                         front_diff(pat), front_bank, gen_count);
    end
  endtask

  task automatic test_reset_mid_sweep;
    clear_pat;
    for (int i = 0; i < N; i++) pat[i] = ($urandom_range(0, 2) == 0);
    load_front(pat);
    step_req = 1'b1;
    tick;
    step_req = 1'b0;
    repeat (150 * 11 + 4) tick;
    rst = 1'b1;
    tick;
    checks++;
    if ({rd_en, wr_en, wr_data, front_bank, busy} !== 5'b0 || rd_addr !== '0 ||
        wr_addr !== '0 || gen_count !== '0) begin
      errors++; $display("FAIL reset_mid: rd_en=%b wr_en=%b front=%b busy=%b gen=%0d expected all 0",
                         rd_en, wr_en, front_bank, busy, gen_count);
    end
    rst = 1'b0;
    tick;
    load_front(pat);
    do_generation(3, 1'b0);
  endtask

  task automatic test_blinker;
    bit orig [N];
    apply_reset;
    clear_pat;
    set_pat(8, 8); set_pat(8, 9); set_pat(8, 10);
    orig = pat;
    load_front(pat);
    do_generation(10, 1'b0);
    clear_pat;
    set_pat(7, 9); set_pat(8, 9); set_pat(9, 9);
    checks++;
    if (front_diff(pat) != 0 || front_bank !== 1'b1) begin
      errors++; $display("FAIL blinker_gen1: diff=%0d front=%b expected 0/1", front_diff(pat), front_bank);
    end
    do_generation(10, 1'b0);
    checks++;
    if (front_diff(orig) != 0 || front_bank !== 1'b0 || gen_count !== GEN_W'(2)) begin
      errors++; $display("FAIL blinker_gen2: diff=%0d front=%b gen=%0d expected 0/0/2",
                         front_diff(orig), front_bank, gen_count);
    end
  endtask

  task automatic test_corner_cell;
    bit dead [N];
    apply_reset;
    clear_pat;
    for (int i = 0; i < N; i++) dead[i] = 1'b0;
    set_pat(0, 0);
    load_front(pat);
    do_generation(2, 1'b0);
    checks++;
    if (front_diff(dead) != 0) begin
      errors++; $display("FAIL corner: %0d live cells expected 0", N - front_diff(dead) == N ? 0 : front_diff(dead));
    end
  endtask

  task automatic test_random_spam;
    apply_reset;
    clear_pat;
    for (int i = 0; i < N; i++) pat[i] = ($urandom_range(0, 2) == 0);
    load_front(pat);
    do_generation(5000, 1'b1);
    do_generation(int'($urandom_range(1, 40)), 1'b1);
  endtask

  initial begin
    test_reset;
    test_block;
    test_reset_mid_sweep;
    test_blinker;
    test_corner_cell;
    test_random_spam;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
